// File: rtl/acc_offload_ctrl.sv
// rtl/acc_offload_ctrl.sv - offload controller between core decoder and accelerator predecoder
// Optional registered predecoder query stage: ACC_OFFLOAD_CTRL_PRD_REG_EN
package acc_pkg;
   typedef struct packed {
      logic [31:0] q_instr_data;
   } prd_req_t;

   typedef struct packed {
      logic       p_accept;
      logic       p_writeback;
      logic [2:0] p_use_rs;
   } prd_rsp_t;
endpackage

module acc_offload_ctrl #(
   parameter int DataWidth      = 32,
   parameter int NumRs          = 3,
   parameter int MaxOutstanding = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              instr_valid_i,
   output logic                              instr_ready_o,
   input  logic [31:0]                       instr_data_i,
   output logic                              illegal_o,
   output acc_pkg::prd_req_t                 prd_req_o,
   input  acc_pkg::prd_rsp_t                 prd_rsp_i,
   input  logic [NumRs-1:0][DataWidth-1:0]   rs_i,
   input  logic [NumRs-1:0]                  rs_valid_i,
   output logic                              acc_q_valid_o,
   input  logic                              acc_q_ready_i,
   output logic [31:0]                       acc_q_instr_o,
   output logic [NumRs-1:0][DataWidth-1:0]   acc_q_rs_o,
   input  logic                              acc_p_valid_i,
   output logic                              acc_p_ready_o,
   input  logic [DataWidth-1:0]              acc_p_data_i,
   input  logic [4:0]                        acc_p_rd_i,
   output logic                              wb_valid_o,
   input  logic                              wb_ready_i,
   output logic [DataWidth-1:0]              wb_data_o,
   output logic [4:0]                        wb_rd_o,
   output logic                              busy_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic [1:0] {IDLE, PREDEC, WAIT_RS, ISSUE} state_e;

   state_e                          state_q, state_d;
   logic [31:0]                     instr_q, instr_d;
   logic [NumRs-1:0]                use_rs_q, use_rs_d;
   logic                            wb_q, wb_d;
   logic [NumRs-1:0][DataWidth-1:0] rs_q, rs_d;
   logic [CntW-1:0]                 out_cnt_q, out_cnt_d;

   logic rs_ok, cnt_ok, issue_wb, resp_hs;

   assign rs_ok  = &(rs_valid_i | ~use_rs_q);
   assign cnt_ok = !wb_q || (out_cnt_q < MaxCnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         use_rs_q  <= '0;
         wb_q      <= 1'b0;
         rs_q      <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         use_rs_q  <= use_rs_d;
         wb_q      <= wb_d;
         rs_q      <= rs_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      use_rs_d = use_rs_q;
      wb_d     = wb_q;
      rs_d     = rs_q;
      case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
`ifdef ACC_OFFLOAD_CTRL_PRD_REG_EN
               instr_d = instr_data_i;
               state_d = PREDEC;
`else
               if (prd_rsp_i.p_accept) begin
                  instr_d  = instr_data_i;
                  use_rs_d = prd_rsp_i.p_use_rs;
                  wb_d     = prd_rsp_i.p_writeback;
                  state_d  = WAIT_RS;
               end
`endif
            end
         end
`ifdef ACC_OFFLOAD_CTRL_PRD_REG_EN
         PREDEC: begin
            if (prd_rsp_i.p_accept) begin
               use_rs_d = prd_rsp_i.p_use_rs;
               wb_d     = prd_rsp_i.p_writeback;
               state_d  = WAIT_RS;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         WAIT_RS: begin
            // Operands are frozen here; later rs_i changes cannot reach the issued request.
            if (rs_ok && cnt_ok) begin
               for (int j = 0; j < NumRs; j++) begin
                  rs_d[j] = use_rs_q[j] ? rs_i[j] : '0;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (acc_q_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      instr_ready_o = (state_q == IDLE);
      acc_q_valid_o = (state_q == ISSUE);
      acc_q_instr_o = instr_q;
      acc_q_rs_o    = rs_q;
      prd_req_o.q_instr_data = (state_q == IDLE) ? instr_data_i : instr_q;
`ifdef ACC_OFFLOAD_CTRL_PRD_REG_EN
      illegal_o = (state_q == PREDEC) && !prd_rsp_i.p_accept;
`else
      illegal_o = (state_q == IDLE) && instr_valid_i && !prd_rsp_i.p_accept;
`endif
      busy_o = (state_q != IDLE) || (out_cnt_q != '0);
   end

   assign wb_valid_o    = acc_p_valid_i;
   assign acc_p_ready_o = wb_ready_i;
   assign wb_data_o     = acc_p_data_i;
   assign wb_rd_o       = acc_p_rd_i;

   // A stray response at zero is still forwarded but must not wrap the counter.
   assign issue_wb = acc_q_valid_o && acc_q_ready_i && wb_q;
   assign resp_hs  = acc_p_valid_i && wb_ready_i && (out_cnt_q != '0);

   always_comb begin
      out_cnt_d = out_cnt_q;
      case ({issue_wb, resp_hs})
         2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
         2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
         default: out_cnt_d = out_cnt_q;
      endcase
   end

endmodule
